// File: rtl/sdp_bram_be_if.sv
// Bus bundle for sdp_bram_be: write port A, read port B and status outputs.
// The master side drives requests; the slave side is the RAM.
interface sdp_bram_be_if #(
  parameter int WID  = 32,
  parameter int SIZE = 256
);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic              ena;
  logic [WID/8-1:0]  wea;
  logic [AW-1:0]     addra;
  logic [WID-1:0]    dina;
  logic              enb;
  logic [AW-1:0]     addrb;
  logic [WID-1:0]    doutb;
  logic              doutb_valid;
  logic              init_busy;

  modport master (
    output ena, wea, addra, dina, enb, addrb,
    input  doutb, doutb_valid, init_busy
  );

  modport slave (
    input  ena, wea, addra, dina, enb, addrb,
    output doutb, doutb_valid, init_busy
  );
endinterface

// File: rtl/sdp_bram_be.sv
// Simple dual-port block RAM with per-byte write enables, self-clearing after reset.
// Collision policy: read-first by default, write-first when SDP_BRAM_BYPASS_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | zeroing the array one word per cycle; user requests ignored
// READY | normal operation
module sdp_bram_be #(
  parameter int WID     = 32,
  parameter int SIZE    = 256,
  parameter int OUT_REG = 0
) (
  input logic          clk,
  input logic          rstn,
  sdp_bram_be_if.slave bus
);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int NB = WID / 8;

  generate
    if (WID % 8 != 0) begin : g_wid_chk
      $fatal(1, "sdp_bram_be: WID must be a multiple of 8");
    end
  endgenerate

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic          ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + AW'(1);
        if (clr_cnt == AW'(SIZE - 1)) begin
          state_nxt   = READY;
          clr_cnt_nxt = '0;
        end
      end
      READY: begin
        state_nxt = READY;
      end
    endcase
  end

  assign ready         = (state == READY);
  assign bus.init_busy = ~ready;

  // Out-of-range writes only exist when SIZE is not a power of two.
  logic wr_in_range;
  generate
    if (SIZE == (1 << AW)) begin : g_pow2
      assign wr_in_range = 1'b1;
    end else begin : g_npow2
      assign wr_in_range = (bus.addra < AW'(SIZE));
    end
  endgenerate

  logic           wr_en;
  logic [NB-1:0]  wr_be;
  logic [AW-1:0]  wr_addr;
  logic [WID-1:0] wr_data;

  // The clear sequencer borrows the write port so the array itself never needs a reset.
  always_comb begin
    wr_en   = 1'b1;
    wr_be   = '1;
    wr_addr = clr_cnt;
    wr_data = '0;
    if (ready) begin
      wr_en   = bus.ena && wr_in_range;
      wr_be   = bus.wea;
      wr_addr = bus.addra;
      wr_data = bus.dina;
    end
  end

  (* ram_style = "block" *) logic [WID-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  logic           rd_req;
  logic           rd_v1;
  logic [WID-1:0] ram_q;
  logic [WID-1:0] rd_data1;

  assign rd_req = ready && bus.enb;

  // ram_q only loads on an accepted read, so it holds between results.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_v1 <= 1'b0;
      ram_q <= '0;
    end else begin
      rd_v1 <= rd_req;
      if (rd_req) ram_q <= mem[bus.addrb];
    end
  end

`ifdef SDP_BRAM_BYPASS_EN
  logic           byp_hit;
  logic [NB-1:0]  byp_be;
  logic [WID-1:0] byp_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byp_hit  <= 1'b0;
      byp_be   <= '0;
      byp_data <= '0;
    end else if (rd_req) begin
      byp_hit  <= wr_en && (bus.addra == bus.addrb);
      byp_be   <= bus.wea;
      byp_data <= bus.dina;
    end
  end

  always_comb begin
    rd_data1 = ram_q;
    for (int i = 0; i < NB; i++) begin
      if (byp_hit && byp_be[i]) rd_data1[8*i +: 8] = byp_data[8*i +: 8];
    end
  end
`else
  assign rd_data1 = ram_q;
`endif

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WID-1:0] dout_q;
      logic           v2;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dout_q <= '0;
          v2     <= 1'b0;
        end else begin
          v2 <= rd_v1;
          if (rd_v1) dout_q <= rd_data1;
        end
      end

      assign bus.doutb       = dout_q;
      assign bus.doutb_valid = v2;
    end else begin : g_noreg
      assign bus.doutb       = rd_data1;
      assign bus.doutb_valid = rd_v1;
    end
  endgenerate
endmodule

// File: tb/tb_sdp_bram_be.sv
// Bench for sdp_bram_be: OUT_REG=0 and OUT_REG=1 instances driven in lockstep,
// results checked against a reference memory through per-instance scoreboards.
module tb_sdp_bram_be;
  localparam int WID  = 32;
  localparam int SIZE = 16;
  localparam int AW   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc++;

  sdp_bram_be_if #(.WID(WID), .SIZE(SIZE)) if0 ();
  sdp_bram_be_if #(.WID(WID), .SIZE(SIZE)) if1 ();

  sdp_bram_be #(.WID(WID), .SIZE(SIZE), .OUT_REG(0)) dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  sdp_bram_be #(.WID(WID), .SIZE(SIZE), .OUT_REG(1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        q [2][$];
  logic [31:0] model [SIZE];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic ena, input logic [3:0] wea, input logic [AW-1:0] addra,
                       input logic [31:0] dina, input logic enb, input logic [AW-1:0] addrb);
    if0.ena = ena;  if0.wea = wea;  if0.addra = addra;  if0.dina = dina;
    if0.enb = enb;  if0.addrb = addrb;
    if1.ena = ena;  if1.wea = wea;  if1.addra = addra;  if1.dina = dina;
    if1.enb = enb;  if1.addrb = addrb;
  endtask

  // One cycle of stimulus; when rdy the reference model predicts read data and applies the write.
  task automatic step(input logic ena, input logic [3:0] wea, input logic [AW-1:0] addra,
                      input logic [31:0] dina, input logic enb, input logic [AW-1:0] addrb,
                      input bit rdy);
    logic [31:0] rd;
    exp_t        e;
    @(negedge clk);
    drive(ena, wea, addra, dina, enb, addrb);
    rd = model[addrb];
`ifdef SDP_BRAM_BYPASS_EN
    if (ena && addra == addrb)
      for (int i = 0; i < 4; i++) if (wea[i]) rd[8*i +: 8] = dina[8*i +: 8];
`endif
    if (rdy && enb) begin
      e.d = rd;
      e.due = cyc + 1;  q[0].push_back(e);
      e.due = cyc + 2;  q[1].push_back(e);
    end
    if (rdy && ena)
      for (int i = 0; i < 4; i++) if (wea[i]) model[addra][8*i +: 8] = dina[8*i +: 8];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SIZE; i++) model[i] = 32'h0;
  endtask

  // Counts cycles until init_busy drops; optionally hammers both ports meanwhile.
  task automatic measure_clear(input string tag, input logic poke);
    int n;
    n = 0;
    chk({tag, "_busy_start"}, {31'h0, if0.init_busy}, 32'h1);
    while (if0.init_busy && n < 100) begin
      @(negedge clk);
      n++;
      if (if0.init_busy) drive(poke, 4'hF, n[3:0], 32'hFFFF_FFFF, poke, n[3:0]);
      else               drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    end
    chk({tag, "_len"}, n, SIZE);
    chk({tag, "_busy_end1"}, {31'h0, if1.init_busy}, 32'h0);
  endtask

  task automatic mon(input int k, input logic v, input logic [31:0] d);
    exp_t e;
    if (q[k].size() != 0 && q[k][0].due < cyc) begin
      e = q[k].pop_front();
      chk($sformatf("missed_valid%0d", k), {31'h0, v}, 32'h1);
    end
    if (v) begin
      if (q[k].size() == 0) begin
        chk($sformatf("spurious_valid%0d", k), {31'h0, v}, 32'h0);
      end else begin
        e = q[k].pop_front();
        chk($sformatf("latency%0d", k), cyc, e.due);
        chk($sformatf("data%0d", k), d, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if0.doutb_valid, if0.doutb);
    mon(1, if1.doutb_valid, if1.doutb);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_dout0",  if0.doutb, 32'h0);
    chk("rst_valid0", {31'h0, if0.doutb_valid}, 32'h0);
    chk("rst_busy0",  {31'h0, if0.init_busy}, 32'h1);
    chk("rst_dout1",  if1.doutb, 32'h0);
    chk("rst_valid1", {31'h0, if1.doutb_valid}, 32'h0);
    chk("rst_busy1",  {31'h0, if1.init_busy}, 32'h1);

    // First clear, with writes and reads attempted throughout.
    rstn = 1'b1;
    measure_clear("clear1", 1'b1);
    model_clear();

    for (int a = 0; a < SIZE; a++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a[3:0], 1'b1);
    idle(4);
    chk("drain1", q[0].size() + q[1].size(), 0);

    // Byte-enable merge on address 3.
    step(1'b1, 4'hF, 4'd3, 32'hAABB_CCDD, 1'b0, 4'd0, 1'b1);
    step(1'b1, 4'h5, 4'd3, 32'h1122_3344, 1'b0, 4'd0, 1'b1);
    step(1'b0, 4'h0, 4'd0, 32'h0,         1'b1, 4'd3, 1'b1);
    idle(4);
    chk("hold_dout0", if0.doutb, 32'hAA22_CC44);
    chk("hold_dout1", if1.doutb, 32'hAA22_CC44);

    // Burst of four reads with an unrelated write to address 8 each cycle.
    for (int a = 0; a < 4; a++) step(1'b1, 4'hF, a[3:0], 32'h10 + a, 1'b0, 4'd0, 1'b1);
    for (int a = 0; a < 4; a++) step(1'b1, 4'hF, 4'd8, 32'hC0DE_0000 + a, 1'b1, a[3:0], 1'b1);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd8, 1'b1);
    idle(4);

    // Write with no byte enables leaves the word untouched.
    step(1'b1, 4'h0, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b1);
    step(1'b0, 4'h0, 4'd0, 32'h0,         1'b1, 4'd3, 1'b1);
    idle(3);

    // Same-address collision on address 5.
    step(1'b1, 4'hF, 4'd5, 32'h0,         1'b0, 4'd0, 1'b1);
    step(1'b1, 4'h3, 4'd5, 32'hFFFF_FFFF, 1'b1, 4'd5, 1'b1);
    idle(3);
`ifdef SDP_BRAM_BYPASS_EN
    chk("collide_dout0", if0.doutb, 32'h0000_FFFF);
    chk("collide_dout1", if1.doutb, 32'h0000_FFFF);
`else
    chk("collide_dout0", if0.doutb, 32'h0000_0000);
    chk("collide_dout1", if1.doutb, 32'h0000_0000);
`endif
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1);
    idle(4);
    chk("drain2", q[0].size() + q[1].size(), 0);

    // Reset aborting a clear at cycle 7, with read requests poked during clear.
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, i[3:0]);
    end
    rstn = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    @(negedge clk);
    chk("abort_busy0", {31'h0, if0.init_busy}, 32'h1);
    rstn = 1'b1;
    measure_clear("clear2", 1'b1);
    model_clear();

    // Read in flight when reset hits.
    step(1'b1, 4'hF, 4'd2, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b1);
    step(1'b0, 4'h0, 4'd0, 32'h0,         1'b1, 4'd2, 1'b1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    q[0].delete();
    q[1].delete();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    @(negedge clk);
    chk("flight_dout0",  if0.doutb, 32'h0);
    chk("flight_valid0", {31'h0, if0.doutb_valid}, 32'h0);
    chk("flight_dout1",  if1.doutb, 32'h0);
    chk("flight_valid1", {31'h0, if1.doutb_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    measure_clear("clear3", 1'b0);
    model_clear();
    idle(6);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b1);
    idle(5);
    chk("drain3", q[0].size() + q[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sdp_bram_be.md
SDP_BRAM_BE -- requirements
Module: sdp_bram_be

Interface
REQ-001 The module SHALL have parameter WID, default 32: data width in bits; it SHALL be a multiple of 8.
REQ-002 The module SHALL have parameter SIZE, default 256: depth in words; address width is $clog2(SIZE).
REQ-003 The module SHALL have parameter OUT_REG, default 0: 0 gives 1-cycle read latency, 1 adds an output register for 2-cycle latency.
REQ-004 The module SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-006 The module SHALL have port ena, input, 1: port A (write) enable.
REQ-007 The module SHALL have port wea, input, WID/8: per-byte write enables; bit i covers dina[8i+7:8i].
REQ-008 The module SHALL have port addra, input, $clog2(SIZE): write address.
REQ-009 The module SHALL have port dina, input, WID: write data.
REQ-010 The module SHALL have port enb, input, 1: port B (read) request.
REQ-011 The module SHALL have port addrb, input, $clog2(SIZE): read address.
REQ-012 The module SHALL have port doutb, output, WID: read data.
REQ-013 The module SHALL have port doutb_valid, output, 1: doutb carries data for an accepted request this cycle.
REQ-014 The module SHALL have port init_busy, output, 1: clear sequence in progress; requests are ignored.

Function
REQ-015 The storage array SHALL be inferred as block RAM (ram_style "block"); the clear sequencer SHALL use the write port and SHALL NOT require a reset on the array.
REQ-016 The init FSM SHALL have states CLEAR and READY; reset SHALL force CLEAR with clear counter = 0.
REQ-017 In CLEAR, each cycle SHALL write all-zero to address counter and increment the counter; after writing SIZE-1 it SHALL go to READY, so CLEAR lasts exactly SIZE cycles after rstn deasserts.
REQ-018 init_busy SHALL be 1 in CLEAR and 0 in READY.
REQ-019 In CLEAR, ena/wea and enb SHALL be ignored: no user write and doutb_valid stays 0.
REQ-020 In READY, on ena=1, each byte i with wea[i]=1 SHALL be written at the clock edge; bytes with wea[i]=0 SHALL be unchanged; ena=1 with wea=0 SHALL be a no-op.
REQ-021 In READY, an enb=1 request at edge N SHALL produce doutb and doutb_valid=1 after edge N+1+OUT_REG, with doutb_valid high for exactly one cycle per request.
REQ-022 Back-to-back requests SHALL be accepted every cycle, with results returned in order and at full throughput.
REQ-023 While no result is presented, doutb SHALL hold its last value and doutb_valid SHALL be 0.
REQ-024 A same-cycle write and read to the same address SHALL follow REQ-033/REQ-034; different addresses SHALL NOT interact.
REQ-025 Out-of-range addresses (SIZE not a power of two) SHALL be ignored on write and return undefined data on read, with doutb_valid still asserted.
REQ-026 If WID is not a multiple of 8, elaboration SHALL fail with a fatal error.

Reset
REQ-027 During reset, doutb SHALL be 0, doutb_valid 0, init_busy 1, and the output pipeline cleared.
REQ-028 rstn asserted mid-CLEAR SHALL abort the sequence; on release, CLEAR SHALL restart from address 0 and run a full SIZE cycles.
REQ-029 rstn asserted with reads in flight SHALL discard them; no doutb_valid SHALL follow reset release until a new READY request is made.
REQ-030 Memory contents SHALL be considered undefined until CLEAR completes.

Configuration
REQ-031 Macro SDP_BRAM_BYPASS_EN SHALL select collision behaviour.
REQ-032 The module SHALL implement REQ-033 or REQ-034 depending on SDP_BRAM_BYPASS_EN.
REQ-033 Without SDP_BRAM_BYPASS_EN, a same-address collision SHALL be read-first: the read returns the pre-write word.
REQ-034 With SDP_BRAM_BYPASS_EN, a same-address collision SHALL be write-first: the read returns written bytes from dina merged with old bytes where wea[i]=0, implemented as a registered compare-and-mux outside the array.

Verification
REQ-035 WID=32, SIZE=16: release rstn -> init_busy=1 for exactly 16 cycles, then 0; reads of all 16 addresses -> 0x00000000.
REQ-036 Write 0xAABBCCDD at address 3 with wea=4'b1111, then wea=4'b0101 and dina=0x11223344 -> read of address 3 returns 0xAA22CC44.
REQ-037 OUT_REG=0 and 1: enb on 4 consecutive cycles for addresses 0..3 holding 0x10..0x13 -> 4 consecutive valid pulses starting 1 and 2 cycles later, respectively, data in order.
REQ-038 Address 5=0x0, same-cycle write of 0xFFFFFFFF, wea=4'b0011, and read of address 5 -> 0x00000000 without the macro, 0x0000FFFF with it.
REQ-039 Assert rstn low at CLEAR cycle 7, release -> init_busy=1 for a full SIZE cycles again; enb pulses during CLEAR -> no doutb_valid.
REQ-040 Read in flight when rstn asserts -> doutb=0 and doutb_valid=0 with no stale pulse after release.
